param_sram: RTL and testbench
=============================

Name: param_sram

Overview:
- Parametrised single-port synchronous SRAM, the successor to the 8-bit x 128 byte SRAM.
- Generalised data width and depth.
- Adds per-byte write enables, a registered read-valid flag, a conflict flag, and a post-reset hardware clear sequencer.
- Sits behind the memory-subsystem request logic; one access per cycle, one clock domain.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; byte lanes NB = DATA_WIDTH/8.
- ADDR_WIDTH, 7, index width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- sram_clk  in  1  clock, all logic on the rising edge.
- sram_ares  in  1  reset, asynchronous, active-high.
- wr_enable  in  1  write request.
- rd_enable  in  1  read request.
- ram_index  in  ADDR_WIDTH  entry address.
- sram_data_in  in  DATA_WIDTH  write data.
- sram_byte_en  in  NB  per-byte write mask; bit k covers data[8k+7:8k].
- sram_par_inject  in  1  inverts stored parity on a write (used only with the macro).
- sram_data_out  out  DATA_WIDTH  registered read data.
- sram_rd_valid  out  1  sram_data_out holds valid read data this cycle.
- sram_busy  out  1  clear sequence in progress; requests ignored.
- sram_conflict  out  1  one-cycle pulse: wr_enable and rd_enable both sampled high.
- sram_par_err  out  1  one-cycle pulse with sram_rd_valid on a parity mismatch.

Behaviour:
- Reset, asynchronous:
  - sram_data_out = 0; sram_rd_valid, sram_conflict and sram_par_err = 0.
  - sram_busy = 1; FSM goes to CLEAR with clear counter = 0.
  - The array itself has no reset.
- FSM states:
  - CLEAR: each cycle writes all-zero data (and correct parity) to entry[counter], then increments the counter. When counter == DEPTH-1 is written, go to IDLE.
  - IDLE: serve requests.
- Busy timing:
  - sram_busy is 1 from reset until the cycle after the last clear write, i.e. DEPTH cycles after the first rising edge with reset low.
  - wr_enable and rd_enable are ignored while busy: no write, no read, sram_rd_valid = 0, no conflict pulse.
- Reset asserted mid-CLEAR or mid-IDLE: the FSM restarts CLEAR from entry 0. Reads after CLEAR completes return 0 for every entry.
- Requests in IDLE, sampled at the rising edge:
  - wr=1, rd=0: for each k with sram_byte_en[k]=1, byte k of entry[ram_index] is updated; other bytes are unchanged. sram_byte_en = 0 is a legal no-op. Next cycle: sram_data_out = 0, sram_rd_valid = 0.
  - wr=0, rd=1: next cycle, sram_data_out = entry[ram_index] and sram_rd_valid = 1. Read latency is 1 cycle.
  - wr=0, rd=0 (stall): next cycle, sram_data_out = 0 and sram_rd_valid = 0.
  - wr=1, rd=1 (conflict): no write and no read. Next cycle: sram_data_out = 0, sram_rd_valid = 0, sram_conflict = 1 for that one cycle.
- Data output rules:
  - sram_data_out is 0 in every cycle where sram_rd_valid = 0; it does not hold stale data.
  - Back-to-back reads give one result per cycle.
- Ordering:
  - A write then a read of the same index on the next edge returns the new data.
  - No same-cycle bypass is needed, since port arbitration forbids a simultaneous read and write.
- Index: ram_index is used as given; the full range is legal, so there is no out-of-range case.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Each entry stores NB extra bits, one even-parity bit per byte.
  - A write computes parity only for the enabled bytes; each stored bit is inverted when sram_par_inject = 1.
  - CLEAR writes correct parity.
  - On a read, if any byte's parity mismatches, sram_par_err = 1 in the same cycle as sram_rd_valid. Data is returned unmodified.
- Not defined:
  - No parity storage.
  - sram_par_err is tied to 0 and sram_par_inject is ignored.
  - Port list is unchanged.

Test Plan:
- Release reset and count cycles -> sram_busy is high for exactly 128 cycles (default params). A read of index 0x7F issued during busy gives sram_rd_valid = 0. After busy drops, reads of indices 0x00, 0x40 and 0x7F return 0x00000000.
- Write index i with data {4{i[7:0]}} and sram_byte_en = 4'hF for all 128 indices, reading each back one cycle after its write -> data matches and sram_rd_valid = 1 exactly one cycle after each read edge.
- Byte mask: write 0xAABBCCDD with mask 4'hF to index 5, then 0x11223344 with mask 4'b0101 -> reading index 5 returns 0xAA22CC44.
- Stall and conflict:
  - wr=rd=0 for 2 cycles -> sram_data_out = 0 and sram_rd_valid = 0.
  - Then wr=rd=1 on index 3 with data 0xFFFFFFFF -> sram_conflict pulses once, and a later read of index 3 returns its prior value.
- Reset mid-access: write 0x12345678 to index 9, then assert sram_ares during a read -> outputs go to 0 immediately, CLEAR restarts, and reading index 9 after busy drops returns 0.
- With SRAM_PARITY_EN: write index 2 with sram_par_inject = 1 -> reading it gives sram_par_err = 1 together with sram_rd_valid. Rewriting it with inject = 0 and reading again gives sram_par_err = 0.

Source files
------------

// File: rtl/param_sram.sv
// param_sram: parametrised single-port synchronous SRAM.
// One access per cycle, registered read data with a valid flag, per-byte
// write enables, a conflict pulse when read and write are requested together,
// and a hardware clear sequencer that zeroes every entry after reset.
// Optional per-byte even parity is built when SRAM_PARITY_EN is defined;
// without it sram_par_err is tied low and sram_par_inject is ignored.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing entry[clr_cnt] each cycle; requests ignored, busy=1
// ST_IDLE  | serving read/write requests
module param_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                    sram_clk,
    input  logic                    sram_ares,
    input  logic                    wr_enable,
    input  logic                    rd_enable,
    input  logic [ADDR_WIDTH-1:0]   ram_index,
    input  logic [DATA_WIDTH-1:0]   sram_data_in,
    input  logic [DATA_WIDTH/8-1:0] sram_byte_en,
    input  logic                    sram_par_inject,
    output logic [DATA_WIDTH-1:0]   sram_data_out,
    output logic                    sram_rd_valid,
    output logic                    sram_busy,
    output logic                    sram_conflict,
    output logic                    sram_par_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic do_wr;
    logic do_rd;
    logic do_conflict;

    assign sram_busy   = (state == ST_CLEAR);
    assign do_wr       = !sram_busy && wr_enable && !rd_enable;
    assign do_rd       = !sram_busy && rd_enable && !wr_enable;
    assign do_conflict = !sram_busy && wr_enable && rd_enable;

    // Clear sequencer: walk every entry once after reset, then serve requests.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + CNT_ONE;
            if (&clr_cnt) begin
                state <= ST_IDLE;
            end
        end
    end

    // Storage array (no reset): zero-fill while clearing, byte-masked writes when idle.
    always_ff @(posedge sram_clk) begin
        if (sram_busy) begin
            mem[clr_cnt] <= '0;
        end else if (do_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (sram_byte_en[k]) begin
                    mem[ram_index][8*k +: 8] <= sram_data_in[8*k +: 8];
                end
            end
        end
    end

    // Output register: data is forced to zero whenever it is not a read result.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) begin
            sram_data_out <= '0;
            sram_rd_valid <= 1'b0;
            sram_conflict <= 1'b0;
        end else begin
            sram_data_out <= do_rd ? mem[ram_index] : '0;
            sram_rd_valid <= do_rd;
            sram_conflict <= do_conflict;
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int k = 0; k < NB; k++) begin
            p[k] = ^d[8*k +: 8];
        end
        return p;
    endfunction

    // Parity store: one even-parity bit per byte, updated only for enabled lanes.
    always_ff @(posedge sram_clk) begin
        if (sram_busy) begin
            par_mem[clr_cnt] <= '0;
        end else if (do_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (sram_byte_en[k]) begin
                    par_mem[ram_index][k] <= (^sram_data_in[8*k +: 8]) ^ sram_par_inject;
                end
            end
        end
    end

    // Parity check on reads, aligned with sram_rd_valid.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) begin
            sram_par_err <= 1'b0;
        end else begin
            sram_par_err <= do_rd && (|(par_mem[ram_index] ^ byte_parity(mem[ram_index])));
        end
    end
`else
    logic par_inject_unused;
    assign par_inject_unused = sram_par_inject;
    assign sram_par_err      = 1'b0;
`endif

endmodule

// File: tb/tb_param_sram.sv
// Self-checking bench for param_sram with a behavioural array model.
module tb_param_sram;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          wr;
    logic          rd;
    logic [AW-1:0] idx;
    logic [DW-1:0] din;
    logic [NB-1:0] be;
    logic          inject;
    logic [DW-1:0] dout;
    logic          valid;
    logic          busy;
    logic          conflict;
    logic          par_err;

    logic [DW-1:0] model_mem [DEPTH];
    logic [NB-1:0] model_bad [DEPTH];

    int checks   = 0;
    int failures = 0;

    param_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .sram_clk        (clk),
        .sram_ares       (rst),
        .wr_enable       (wr),
        .rd_enable       (rd),
        .ram_index       (idx),
        .sram_data_in    (din),
        .sram_byte_en    (be),
        .sram_par_inject (inject),
        .sram_data_out   (dout),
        .sram_rd_valid   (valid),
        .sram_busy       (busy),
        .sram_conflict   (conflict),
        .sram_par_err    (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            model_bad[i] = '0;
        end
    endtask

    // Wait out the clear sequence, holding a read request, and check its length.
    task automatic wait_clear(input logic [AW-1:0] probe_idx);
        int n;
        n   = 0;
        wr  = 1'b0;
        rd  = 1'b1;
        idx = probe_idx;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            n++;
            chk("busy_rd_valid", {63'd0, valid}, 64'd0);
            chk("busy_dout", {32'd0, dout}, 64'd0);
        end
        chk("busy_len", 64'(n), 64'(DEPTH));
        rd = 1'b0;
    endtask

    // One access cycle, checked against the array model.
    task automatic access(input logic w, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NB-1:0] m, input logic inj);
        logic [DW-1:0] exp_d;
        logic          exp_v;
        logic          exp_c;
        logic          exp_p;
        wr = w; rd = r; idx = a; din = d; be = m; inject = inj;
        exp_d = '0; exp_v = 1'b0; exp_c = 1'b0; exp_p = 1'b0;
        if (w && r) begin
            exp_c = 1'b1;
        end else if (r) begin
            exp_d = model_mem[a];
            exp_v = 1'b1;
`ifdef SRAM_PARITY_EN
            exp_p = |model_bad[a];
`endif
        end else if (w) begin
            for (int k = 0; k < NB; k++) begin
                if (m[k]) begin
                    model_mem[a][8*k +: 8] = d[8*k +: 8];
                    model_bad[a][k]        = inj;
                end
            end
        end
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("dout", {32'd0, dout}, {32'd0, exp_d});
        chk("rd_valid", {63'd0, valid}, {63'd0, exp_v});
        chk("conflict", {63'd0, conflict}, {63'd0, exp_c});
        chk("par_err", {63'd0, par_err}, {63'd0, exp_p});
        chk("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; idx = '0; din = '0; be = '0; inject = 1'b0;
        model_clear();
        #12;
        chk("rst_dout", {32'd0, dout}, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_conflict", {63'd0, conflict}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        wait_clear(7'h7F);

        // Cleared array reads as zero.
        access(1'b0, 1'b1, 7'h00, '0, '0, 1'b0);
        access(1'b0, 1'b1, 7'h40, '0, '0, 1'b0);
        access(1'b0, 1'b1, 7'h7F, '0, '0, 1'b0);

        // Fill every entry with its index pattern, reading each back immediately.
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(i);
            access(1'b1, 1'b0, AW'(i), {4{b}}, 4'hF, 1'b0);
            access(1'b0, 1'b1, AW'(i), '0, '0, 1'b0);
            chk("fill_pattern", {32'd0, dout}, {32'd0, {4{b}}});
        end

        // Byte mask merge.
        access(1'b1, 1'b0, 7'd5, 32'hAABBCCDD, 4'hF, 1'b0);
        access(1'b1, 1'b0, 7'd5, 32'h11223344, 4'b0101, 1'b0);
        access(1'b0, 1'b1, 7'd5, '0, '0, 1'b0);
        chk("byte_mask", {32'd0, dout}, 64'hAA22CC44);
        access(1'b1, 1'b0, 7'd6, 32'hDEADBEEF, 4'h0, 1'b0);
        access(1'b0, 1'b1, 7'd6, '0, '0, 1'b0);
        chk("mask_zero_noop", {32'd0, dout}, 64'h06060606);

        // Stall, then conflict on index 3, then confirm index 3 untouched.
        access(1'b0, 1'b0, 7'd3, 32'h5A5A5A5A, 4'hF, 1'b0);
        access(1'b0, 1'b0, 7'd3, 32'h5A5A5A5A, 4'hF, 1'b0);
        access(1'b1, 1'b1, 7'd3, 32'hFFFFFFFF, 4'hF, 1'b0);
        chk("conflict_pulse", {63'd0, conflict}, 64'd1);
        access(1'b0, 1'b0, 7'd3, '0, '0, 1'b0);
        chk("conflict_one_cycle", {63'd0, conflict}, 64'd0);
        access(1'b0, 1'b1, 7'd3, '0, '0, 1'b0);
        chk("conflict_no_write", {32'd0, dout}, 64'h03030303);

        // Back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b1, AW'(i * 9), '0, '0, 1'b0);
        end

`ifdef SRAM_PARITY_EN
        access(1'b1, 1'b0, 7'd2, 32'hCAFEF00D, 4'hF, 1'b1);
        access(1'b0, 1'b1, 7'd2, '0, '0, 1'b0);
        chk("par_inject_err", {63'd0, par_err}, 64'd1);
        access(1'b1, 1'b0, 7'd2, 32'hCAFEF00D, 4'hF, 1'b0);
        access(1'b0, 1'b1, 7'd2, '0, '0, 1'b0);
        chk("par_clean", {63'd0, par_err}, 64'd0);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            access(op[0] || op[3], op[1] || (op[2] && op[3]), AW'($urandom),
                   DW'($urandom), NB'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Reset during a read: outputs drop at once and the array is cleared again.
        access(1'b1, 1'b0, 7'd9, 32'h12345678, 4'hF, 1'b0);
        wr = 1'b0; rd = 1'b1; idx = 7'd9;
        tick();
        chk("pre_reset_read", {32'd0, dout}, 64'h12345678);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dout", {32'd0, dout}, 64'd0);
        chk("async_rst_valid", {63'd0, valid}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd1);
        tick();
        rst = 1'b0;
        model_clear();
        wait_clear(7'd9);
        access(1'b0, 1'b1, 7'd9, '0, '0, 1'b0);
        chk("after_reclear", {32'd0, dout}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 1'b1, AW'($urandom), '0, '0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
